// File: rtl/conv2d_sched.sv
// conv2d_sched: tap-level scheduler for one conv2d layer.
// Walks pixels and kernel taps for a shared MAC and hands off each pixel.
module conv2d_sched #(
  parameter int INPUT_CHANNELS  = 1,
  parameter int OUTPUT_CHANNELS = 1,
  parameter int HEIGHT          = 28,
  parameter int WIDTH           = 28,
  parameter int KERNEL_SIZE     = 3,
  parameter int PADDING         = 1,
  parameter int STRIDE          = 1,
  parameter int MAC_LAT         = 2,
  localparam int IC  = INPUT_CHANNELS,
  localparam int OC  = OUTPUT_CHANNELS,
  localparam int H   = HEIGHT,
  localparam int W   = WIDTH,
  localparam int K   = KERNEL_SIZE,
  localparam int P   = PADDING,
  localparam int S   = STRIDE,
  localparam int OH  = (H - K + 2 * P) / S + 1,
  localparam int OW  = (W - K + 2 * P) / S + 1,
  localparam int FAW = (IC * H * W > 1) ? $clog2(IC * H * W) : 1,
  localparam int WAW = (OC * IC * K * K > 1) ? $clog2(OC * IC * K * K) : 1,
  localparam int OAW = (OC * OH * OW > 1) ? $clog2(OC * OH * OW) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [FAW-1:0] fm_addr,
  output logic           fm_pad,
  output logic [WAW-1:0] wt_addr,
  output logic           mac_en,
  output logic           acc_clr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OAW-1:0] out_addr
);

  localparam int ICW = (IC > 1) ? $clog2(IC) : 1;
  localparam int OCW = (OC > 1) ? $clog2(OC) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int OHW = (OH > 1) ? $clog2(OH) : 1;
  localparam int OWW = (OW > 1) ? $clog2(OW) : 1;
  localparam int DW  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [OCW-1:0] oc_q, oc_d;
  logic [OHW-1:0] oy_q, oy_d;
  logic [OWW-1:0] ox_q, ox_d;
  logic [ICW-1:0] ic_q, ic_d;
  logic [KW-1:0]  ky_q, ky_d;
  logic [KW-1:0]  kx_q, kx_d;
  logic [DW-1:0]  dcnt_q, dcnt_d;

  logic [FAW-1:0] fm_addr_q, fm_addr_d;
  logic [WAW-1:0] wt_addr_q, wt_addr_d;
  logic [OAW-1:0] out_addr_q, out_addr_d;
  logic           fm_pad_q, fm_pad_d;
  logic           acc_clr_q, acc_clr_d;

  logic last_tap, last_pix;
  int   iy, ix;

  assign last_tap = (ic_q == ICW'(IC - 1)) &&
                    (ky_q == KW'(K - 1)) &&
                    (kx_q == KW'(K - 1));

  assign last_pix = (oc_q == OCW'(OC - 1)) &&
                    (oy_q == OHW'(OH - 1)) &&
                    (ox_q == OWW'(OW - 1));

  // Next state, loop counters and the tap/pixel outputs for the next cycle
  always_comb begin
    state_d    = state_q;
    oc_d       = oc_q;
    oy_d       = oy_q;
    ox_d       = ox_q;
    ic_d       = ic_q;
    ky_d       = ky_q;
    kx_d       = kx_q;
    dcnt_d     = dcnt_q;
    fm_addr_d  = '0;
    wt_addr_d  = '0;
    out_addr_d = '0;
    fm_pad_d   = 1'b0;
    acc_clr_d  = 1'b0;
    iy         = 0;
    ix         = 0;

    unique case (state_q)
      S_IDLE: begin
        oc_d   = '0;
        oy_d   = '0;
        ox_d   = '0;
        ic_d   = '0;
        ky_d   = '0;
        kx_d   = '0;
        dcnt_d = '0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (last_tap) begin
          ic_d    = '0;
          ky_d    = '0;
          kx_d    = '0;
          dcnt_d  = '0;
          state_d = (MAC_LAT == 0) ? S_OUT : S_DRAIN;
        end else if (kx_q != KW'(K - 1)) begin
          kx_d = kx_q + 1'b1;
        end else if (ky_q != KW'(K - 1)) begin
          kx_d = '0;
          ky_d = ky_q + 1'b1;
        end else begin
          kx_d = '0;
          ky_d = '0;
          ic_d = ic_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DW'(MAC_LAT - 1)) begin
          dcnt_d  = '0;
          state_d = S_OUT;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (last_pix) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            if (ox_q != OWW'(OW - 1)) begin
              ox_d = ox_q + 1'b1;
            end else if (oy_q != OHW'(OH - 1)) begin
              ox_d = '0;
              oy_d = oy_q + 1'b1;
            end else begin
              ox_d = '0;
              oy_d = '0;
              oc_d = oc_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    iy = int'(oy_d) * S + int'(ky_d) - P;
    ix = int'(ox_d) * S + int'(kx_d) - P;

    if (state_d == S_RUN) begin
      fm_pad_d  = (iy < 0) || (iy >= H) || (ix < 0) || (ix >= W);
      acc_clr_d = (state_q != S_RUN);
      wt_addr_d = WAW'(((int'(oc_d) * IC + int'(ic_d)) * K +
                        int'(ky_d)) * K + int'(kx_d));
      if (!fm_pad_d)
        fm_addr_d = FAW'(int'(ic_d) * H * W + iy * W + ix);
    end

    if (state_d == S_OUT)
      out_addr_d = OAW'(int'(oc_d) * OH * OW +
                        int'(oy_d) * OW + int'(ox_d));
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      oc_q       <= '0;
      oy_q       <= '0;
      ox_q       <= '0;
      ic_q       <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      dcnt_q     <= '0;
      fm_addr_q  <= '0;
      wt_addr_q  <= '0;
      out_addr_q <= '0;
      fm_pad_q   <= 1'b0;
      acc_clr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      oc_q       <= oc_d;
      oy_q       <= oy_d;
      ox_q       <= ox_d;
      ic_q       <= ic_d;
      ky_q       <= ky_d;
      kx_q       <= kx_d;
      dcnt_q     <= dcnt_d;
      fm_addr_q  <= fm_addr_d;
      wt_addr_q  <= wt_addr_d;
      out_addr_q <= out_addr_d;
      fm_pad_q   <= fm_pad_d;
      acc_clr_q  <= acc_clr_d;
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN) ||
                     (state_q == S_OUT);
  assign done      = (state_q == S_DONE);
  assign mac_en    = (state_q == S_RUN);
  assign out_valid = (state_q == S_OUT);
  assign fm_addr   = fm_addr_q;
  assign wt_addr   = wt_addr_q;
  assign out_addr  = out_addr_q;
  assign fm_pad    = fm_pad_q;
  assign acc_clr   = acc_clr_q;

endmodule

// File: tb/tb_conv2d_sched.sv
// tb_conv2d_sched: directed bench for conv2d_sched over four configurations.
// Expected output addresses are queued at start; monitors pop on handshakes.
module tb_conv2d_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;
  int   st;

  always @(posedge clk) edge_n++;

  // u0: default layer
  logic       s0, b0, d0, fp0, me0, ac0, ov0, or0;
  logic [9:0] fa0, oa0;
  logic [3:0] wa0;
  // u1: 5x5, P=0, S=2
  logic       s1, b1, d1, fp1, me1, ac1, ov1, or1;
  logic [4:0] fa1;
  logic [3:0] wa1;
  logic [1:0] oa1;
  // u2: IC=OC=2, 4x4
  logic       s2, b2, d2, fp2, me2, ac2, ov2, or2;
  logic [4:0] fa2, oa2;
  logic [5:0] wa2;
  // u3: 4x4, MAC_LAT=0
  logic       s3, b3, d3, fp3, me3, ac3, ov3, or3;
  logic [3:0] fa3, wa3, oa3;

  conv2d_sched u0 (
    .clk(clk), .rst(rst), .start(s0), .busy(b0), .done(d0),
    .fm_addr(fa0), .fm_pad(fp0), .wt_addr(wa0), .mac_en(me0),
    .acc_clr(ac0), .out_valid(ov0), .out_ready(or0), .out_addr(oa0)
  );

  conv2d_sched #(
    .HEIGHT(5), .WIDTH(5), .PADDING(0), .STRIDE(2)
  ) u1 (
    .clk(clk), .rst(rst), .start(s1), .busy(b1), .done(d1),
    .fm_addr(fa1), .fm_pad(fp1), .wt_addr(wa1), .mac_en(me1),
    .acc_clr(ac1), .out_valid(ov1), .out_ready(or1), .out_addr(oa1)
  );

  conv2d_sched #(
    .INPUT_CHANNELS(2), .OUTPUT_CHANNELS(2), .HEIGHT(4), .WIDTH(4)
  ) u2 (
    .clk(clk), .rst(rst), .start(s2), .busy(b2), .done(d2),
    .fm_addr(fa2), .fm_pad(fp2), .wt_addr(wa2), .mac_en(me2),
    .acc_clr(ac2), .out_valid(ov2), .out_ready(or2), .out_addr(oa2)
  );

  conv2d_sched #(
    .HEIGHT(4), .WIDTH(4), .MAC_LAT(0)
  ) u3 (
    .clk(clk), .rst(rst), .start(s3), .busy(b3), .done(d3),
    .fm_addr(fa3), .fm_pad(fp3), .wt_addr(wa3), .mac_en(me3),
    .acc_clr(ac3), .out_valid(ov3), .out_ready(or3), .out_addr(oa3)
  );

  int q0[$];
  int q1[$];
  int q2[$];
  int q3[$];
  int hs0 = 0, hs1 = 0, hs2 = 0, hs3 = 0;
  int run0 = 0;

  int pad_e[9] = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
  int fa_e[9]  = '{0, 0, 0, 0, 0, 1, 0, 28, 29};

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, inout int q[$],
                         input longint act);
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected output %0d, none required", name, act);
    end else begin
      int e;
      e = q.pop_front();
      if (act != e) begin
        errors++;
        $display("FAIL %s: got %0d, required %0d", name, act, e);
      end
    end
  endtask

  // Scoreboard monitors: sample mid-low-phase, after stimulus settles
  always begin
    @(negedge clk);
    #2;
    if (ov0 && or0) begin pop_chk("out_addr0", q0, oa0); hs0++; end
    if (ov1 && or1) begin pop_chk("out_addr1", q1, oa1); hs1++; end
    if (ov2 && or2) begin pop_chk("out_addr2", q2, oa2); hs2++; end
    if (ov3 && or3) begin pop_chk("out_addr3", q3, oa3); hs3++; end
    if (me0) begin
      run0++;
    end else if (run0 != 0) begin
      chk("burst0_len", run0, 9);
      run0 = 0;
    end
  end

  function automatic logic sig(input int id);
    case (id)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      3:       return d3;
      11:      return ov1;
      12:      return ov2;
      13:      return ov3;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int id, input int lim, input string name);
    int n = 0;
    while (!sig(id) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!sig(id)) begin
      checks++;
      errors++;
      $display("FAIL %s: still low after %0d cycles, required high",
               name, lim);
    end
  endtask

  initial begin
    rst = 1'b0;
    {s0, s1, s2, s3} = '0;
    {or0, or1, or2, or3} = '1;
    repeat (2) @(negedge clk);

    chk("rst_busy", b0, 0);
    chk("rst_done", d0, 0);
    chk("rst_mac_en", me0, 0);
    chk("rst_acc_clr", ac0, 0);
    chk("rst_fm_pad", fp0, 0);
    chk("rst_out_valid", ov0, 0);
    chk("rst_fm_addr", fa0, 0);
    chk("rst_wt_addr", wa0, 0);
    chk("rst_out_addr", oa0, 0);
    rst = 1'b1;
    @(negedge clk);

    // Default layer: full run, pixel (0,0) taps, ignored start
    for (int i = 0; i < 784; i++) q0.push_back(i);
    s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    st = edge_n;
    chk("busy0_start", b0, 1);
    for (int t = 0; t < 9; t++) begin
      chk("mac_en0_tap", me0, 1);
      chk("fm_pad0_tap", fp0, pad_e[t]);
      chk("fm_addr0_tap", fa0, fa_e[t]);
      chk("acc_clr0_tap", ac0, (t == 0) ? 1 : 0);
      chk("wt_addr0_tap", wa0, t);
      @(negedge clk);
    end
    chk("mac_en0_drain", me0, 0);
    s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    wait_for(0, 20000, "done0");
    chk("done0_cycle", edge_n - st + 1, 9409);
    chk("busy0_done", b0, 0);
    @(negedge clk);
    chk("done0_width", d0, 0);
    #3;
    chk("hs0_count", hs0, 784);
    chk("q0_left", q0.size(), 0);

    // Strided layer without padding
    for (int i = 0; i < 4; i++) q1.push_back(i);
    s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    st = edge_n;
    wait_for(11, 50, "ov1_first");
    @(negedge clk);
    chk("acc_clr1_pix1", ac1, 1);
    chk("fm_addr1_pix1", fa1, 2);
    chk("fm_pad1_pix1", fp1, 0);
    wait_for(1, 100, "done1");
    chk("done1_cycle", edge_n - st + 1, 49);
    #3;
    chk("hs1_count", hs1, 4);
    chk("q1_left", q1.size(), 0);

    // Two input and two output channels
    for (int i = 0; i < 32; i++) q2.push_back(i);
    s2 = 1'b1;
    @(negedge clk);
    s2 = 1'b0;
    st = edge_n;
    for (int p = 0; p < 16; p++) begin
      wait_for(12, 40, "ov2_pix");
      @(negedge clk);
    end
    chk("acc_clr2_oc1", ac2, 1);
    chk("wt_addr2_oc1", wa2, 18);
    wait_for(12, 40, "ov2_oc1");
    chk("out_addr2_oc1", oa2, 16);
    wait_for(2, 2000, "done2");
    chk("done2_cycle", edge_n - st + 1, 673);
    #3;
    chk("hs2_count", hs2, 32);
    chk("q2_left", q2.size(), 0);

    // Zero MAC latency, back-pressure, reset mid-run
    for (int i = 0; i < 16; i++) q3.push_back(i);
    s3 = 1'b1;
    @(negedge clk);
    s3 = 1'b0;
    for (int t = 0; t < 9; t++) begin
      chk("mac_en3_tap", me3, 1);
      chk("wt_addr3_tap", wa3, t);
      @(negedge clk);
    end
    chk("out_valid3_nolat", ov3, 1);
    chk("mac_en3_out", me3, 0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      wait_for(13, 40, "ov3_pix");
      @(negedge clk);
    end
    or3 = 1'b0;
    wait_for(13, 40, "ov3_bp");
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", ov3, 1);
      chk("bp_out_addr", oa3, 3);
      chk("bp_mac_en", me3, 0);
      if (i < 4) @(negedge clk);
    end
    or3 = 1'b1;
    @(negedge clk);
    chk("bp_next_mac_en", me3, 1);
    chk("bp_next_acc_clr", ac3, 1);
    chk("bp_next_out_valid", ov3, 0);
    @(negedge clk);
    chk("pre_rst_wt_addr", wa3, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", b3, 0);
    chk("mid_rst_mac_en", me3, 0);
    chk("mid_rst_acc_clr", ac3, 0);
    chk("mid_rst_fm_pad", fp3, 0);
    chk("mid_rst_out_valid", ov3, 0);
    chk("mid_rst_fm_addr", fa3, 0);
    chk("mid_rst_wt_addr", wa3, 0);
    chk("mid_rst_out_addr", oa3, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_rst_done", d3, 0);
    end
    rst = 1'b1;
    q3.delete();
    hs3 = 0;
    @(negedge clk);
    chk("post_rst_done", d3, 0);
    for (int i = 0; i < 16; i++) q3.push_back(i);
    s3 = 1'b1;
    @(negedge clk);
    s3 = 1'b0;
    st = edge_n;
    chk("restart_acc_clr", ac3, 1);
    chk("restart_wt_addr", wa3, 0);
    wait_for(3, 400, "done3");
    chk("done3_cycle", edge_n - st + 1, 161);
    #3;
    chk("hs3_count", hs3, 16);
    chk("q3_left", q3.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv2d_sched.md
# conv2d_sched

Tap-level scheduler for the 2-D convolution layer. It time-multiplexes one multiply-accumulate (MAC) datapath over every output pixel of a conv2d layer. For each pixel it walks all input channels and kernel taps and emits feature-map and weight addresses, a zero-padding flag, and MAC control. It then presents the finished pixel's output address on a valid/ready handshake. It sits between the layer sequencer (start/done) and the feature-map RAM, weight ROM, MAC unit and output buffer.

## Interface
- INPUT_CHANNELS, 1, input channels (IC)
- OUTPUT_CHANNELS, 1, output channels (OC)
- HEIGHT, 28, input rows (H)
- WIDTH, 28, input columns (W)
- KERNEL_SIZE, 3, square kernel side (K)
- PADDING, 1, zero border on every side (P)
- STRIDE, 1, window step (S)
- MAC_LAT, 2, MAC pipeline depth in cycles (0 allowed)
- Derived: OH = (H-K+2P)/S+1, OW = (W-K+2P)/S+1, T = IC*K*K taps per pixel; address widths are $clog2 of each space, minimum 1

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; honoured only in IDLE
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse after the last output handshake
- fm_addr  out  $clog2(IC*H*W)  ic*H*W + iy*W + ix; 0 when fm_pad=1
- fm_pad  out  1  tap lies outside the input; datapath substitutes 0
- wt_addr  out  $clog2(OC*IC*K*K)  ((oc*IC+ic)*K+ky)*K+kx
- mac_en  out  1  a tap is issued this cycle
- acc_clr  out  1  with mac_en on the first tap of a pixel; accumulator loads instead of adding
- out_valid  out  1  finished pixel is ready
- out_ready  in  1  output buffer accepts it
- out_addr  out  $clog2(OC*OH*OW)  oc*OH*OW + oy*OW + ox

## Operation
- Loop order, outermost first: oc, oy, ox (pixel loop); then ic, ky, kx (tap loop).
- Coordinates: iy = oy*S + ky - P, ix = ox*S + kx - P. Compute them as signed values one bit wider than needed. fm_pad = (iy<0) | (iy>=H) | (ix<0) | (ix>=W).
- States:
  - IDLE: start goes to RUN; all counters clear.
  - RUN: mac_en=1 every cycle; the tap counters advance. After the last tap (ic=IC-1, ky=kx=K-1), go to DRAIN, or to OUT if MAC_LAT=0.
  - DRAIN: count MAC_LAT cycles, then go to OUT.
  - OUT: out_valid=1. On out_valid&out_ready: if this was the last pixel, go to DONE; otherwise advance the pixel counters, clear the tap counters and go to RUN.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- start outside IDLE is ignored. out_ready outside OUT is ignored.
- fm_addr, wt_addr, fm_pad and acc_clr are registered and valid only when mac_en=1. They are 0 whenever mac_en=0.
- out_addr is stable for the whole time out_valid is high.
- Counter wrap: kx wraps to 0 and increments ky; ky likewise increments ic; ox likewise increments oy; oy likewise increments oc.

## Timing
- Reset: while rst=0, force IDLE and all counters to 0. Outputs busy, done, mac_en, acc_clr, fm_pad, out_valid, fm_addr, wt_addr and out_addr are all 0.
- Reset asserted mid-operation aborts immediately with no done pulse. A later start begins again from pixel 0.
- start sampled high at edge n: busy=1 from n+1. mac_en is high for cycles n+1 .. n+T, with acc_clr at n+1.
- After the taps: MAC_LAT DRAIN cycles, then out_valid.
- Per pixel, with out_ready held high: T + MAC_LAT + 1 cycles. The next pixel's first tap comes the cycle after the handshake.
- done is asserted the cycle after the final handshake, with busy=0 in that cycle. The block can accept start again in the following cycle.
- Back-pressure: OUT is held indefinitely while out_ready=0, with mac_en=0 and no state change.

## Test plan
- Default parameters, out_ready tied high, start at cycle 0:
  - 784 out_valid handshakes, out_addr 0..783 in order.
  - mac_en bursts of exactly 9 cycles.
  - done at cycle 9409 (784*12+1), done pulse one cycle wide.
- Default parameters, pixel (0,0), in tap order:
  - fm_pad pattern 1,1,1,1,0,0,1,0,0.
  - Unpadded fm_addr values 0,1,28,29.
  - acc_clr only on tap 0; wt_addr 0..8.
- H=W=5, K=3, P=0, S=2 (OH=OW=2): pixel (0,1) first tap has fm_addr=2 and fm_pad=0. The run produces 4 outputs.
- IC=2, OC=2, H=W=4, K=3, P=1, S=1 (T=18):
  - First tap of oc=1 has wt_addr=18.
  - First oc=1 output has out_addr=16.
  - 32 outputs in total.
- Back-pressure: out_ready low for 5 cycles on pixel 3. out_valid is held, out_addr=3 is stable, and mac_en=0 throughout. The first tap of pixel 4 comes one cycle after out_ready rises.
- Edge cases:
  - start pulsed while busy has no effect.
  - rst asserted mid-RUN zeroes all outputs immediately.
  - MAC_LAT=0 gives out_valid the cycle after the last tap.
